dmem_responder: RTL and testbench

Data-memory responder for the MIPS core's load/store port. Accepts one word-wide read or write request at a time over a valid/ready handshake, inserts a fixed number of wait states, then holds a registered response until the initiator takes it. Sits between the core's memory-stage request logic and the on-chip data RAM. Flags misaligned or out-of-range accesses instead of performing them.

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-wide data-memory responder with wait states and error flagging.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD =
        c_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [7:0]            r_err_count;
    logic [31:0]           r_mem [c_DEPTH];

    logic                  w_accept;
    logic                  w_req_err;
    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic                  w_direct;
    logic                  w_wait_done;
    logic                  w_do_access;
    logic                  w_acc_write;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic [31:0]           w_acc_wdata;
    logic [3:0]            w_acc_strb;
    logic [31:0]           w_load_data;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_req_err   = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_req_idx   = req_addr[ADDR_WIDTH+1:2];
    assign w_direct    = (WAIT_STATES == 0) && w_accept && !w_req_err;
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == '0);
    // A reset edge wins over a pending access, so an in-flight store is dropped.
    assign w_do_access = !reset && (w_direct || w_wait_done);

    // Zero-wait builds access with the live request; otherwise use the captured copy.
    assign w_acc_write = w_direct ? req_write : r_write;
    assign w_acc_idx   = w_direct ? w_req_idx : r_idx;
    assign w_acc_wdata = w_direct ? req_wdata : r_wdata;
    assign w_acc_strb  = w_direct ? req_wstrb : r_wstrb;
    assign w_load_data = w_acc_write ? 32'd0 : r_mem[w_acc_idx];

    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_strb[i]) begin
                    r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_idx   <= w_req_idx;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        if (w_req_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_RESP;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end else if (WAIT_STATES == 0) begin
                            r_rdata <= w_load_data;
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= c_WAIT_LOAD;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= w_load_data;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Randomized self-checking bench for dmem_responder against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int AW = 8;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [7:0]  err_count;

    logic        req_valid0, req_ready0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_wstrb0;
    logic        resp_valid0, resp_ready0, resp_err0, busy0;
    logic [31:0] resp_rdata0;
    logic [7:0]  err_count0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .err_count(err_count)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .busy(busy0), .err_count(err_count0)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [1 << AW];
    int          model_errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold < 0: resp_ready raised before resp_valid; otherwise held low hold cycles.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat, lat, idx;
        exp_err   = (addr % 4 != 0) || (longint'(addr) >= (longint'(4) << AW));
        idx       = int'((addr / 4) % (1 << AW));
        exp_lat   = exp_err ? 1 : WS + 1;
        exp_rdata = (!exp_err && !wr) ? model_mem[idx] : 32'd0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        tick();
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        if (exp_err) begin
            if (model_errs < 255) model_errs++;
        end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (hold < 0) resp_ready = 1'b1;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            chk("busy_wait", 32'(busy), 32'd1);
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("err_count", 32'(err_count), 32'(model_errs));
        if (hold >= 0) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_rdata", resp_rdata, exp_rdata);
                chk("hold_ready", 32'(req_ready), 32'd0);
            end
            resp_ready = 1'b1;
        end
        tick();
        resp_ready = 1'b0;
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_err", 32'(resp_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
        req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_wstrb0 = 0; resp_ready0 = 0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        for (int i = 0; i < (1 << AW); i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        do_req(1'b0, 32'h12, 32'h0, 4'h0, 0);
        do_req(1'b0, 32'h400, 32'h0, 4'h0, 0);
        do_req(1'b1, 32'h16, 32'hFFFFFFFF, 4'hF, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 5);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, -1);
        do_req(1'b1, 32'h30, $urandom, 4'h0, 0);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 0);

        // Reset during the first WAIT cycle drops the pending store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_wstrb = 4'hF;
        tick();
        req_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_errs = 0;
        chk("wrst_req_ready", 32'(req_ready), 32'd1);
        chk("wrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("wrst_resp_rdata", resp_rdata, 32'd0);
        chk("wrst_resp_err", 32'(resp_err), 32'd0);
        chk("wrst_busy", 32'(busy), 32'd0);
        chk("wrst_err_count", 32'(err_count), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, (1 << AW) - 1) * 4);
            do_req(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)) - 1);
        end

        for (int i = 0; i < 260; i++) begin
            do_req(1'($urandom), 32'(($urandom_range(0, 255) << 2) | $urandom_range(1, 3)),
                   $urandom, 4'hF, 0);
        end
        chk("err_saturated", 32'(err_count), 32'd255);

        resp_ready0 = 1'b1;
        chk("ws0_ready", 32'(req_ready0), 32'd1);
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h8;
        req_wdata0 = 32'hA5A50F0F; req_wstrb0 = 4'hF;
        tick();
        req_valid0 = 1'b0; req_wdata0 = 32'h0;
        chk("ws0_store_valid", 32'(resp_valid0), 32'd1);
        chk("ws0_store_err", 32'(resp_err0), 32'd0);
        chk("ws0_store_rdata", resp_rdata0, 32'd0);
        tick();
        chk("ws0_ready_again", 32'(req_ready0), 32'd1);
        req_valid0 = 1'b1; req_write0 = 1'b0;
        tick();
        req_valid0 = 1'b0;
        chk("ws0_load_valid", 32'(resp_valid0), 32'd1);
        chk("ws0_load_rdata", resp_rdata0, 32'hA5A50F0F);
        tick();
        chk("ws0_done", 32'(resp_valid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
